// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

endpackage : regfile_pkg

// File: rtl/rf_read_port.sv
// One combinational read port: row select, zero-register override and write bypass.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [DATA_W-1:0] rows_i [DEPTH],
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    output logic [DATA_W-1:0] rd_o
);

    logic zero_hit;
    logic byp1_hit;
    logic byp0_hit;

    assign zero_hit = (ZERO_REG != 0) && (ra_i == '0);
    assign byp1_hit = (BYPASS != 0) && we1_i && (wa1_i == ra_i);
    assign byp0_hit = (BYPASS != 0) && we0_i && (wa0_i == ra_i);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        rd_o = rows_i[ra_i];
        if (clear_i || zero_hit) begin
            rd_o = '0;
        end else if (byp1_hit) begin
            rd_o = wd1_i;
        end else if (byp0_hit) begin
            rd_o = wd0_i;
        end
    end

endmodule : rf_read_port

// File: rtl/register_file_mp.sv
// Multi-port register file with prioritised dual write and a row-per-cycle clear sweep.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd0,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic we0_act;
    logic we1_act;
    logic wr0_en;
    logic wr1_en;

    assign busy = (state_q == RF_CLEAR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Port 1 wins a same-address collision by suppressing port 0 outright.
    assign we0_act = we0 && !busy;
    assign we1_act = we1 && !busy;
    assign wr1_en  = we1_act && !((ZERO_REG != 0) && (wa1 == '0));
    assign wr0_en  = we0_act && !((ZERO_REG != 0) && (wa0 == '0))
                     && !(we1_act && (wa1 == wa0));

    // NOTE: storage has no reset branch; the clear sweep zeroes it so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (wr0_en) begin
                mem_q[wa0] <= wd0;
            end
            if (wr1_en) begin
                mem_q[wa1] <= wd1;
            end
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .clear_i (busy),
            .ra_i    (ra[i*ADDR_W +: ADDR_W]),
            .rows_i  (mem_q),
            .we0_i   (we0_act),
            .wa0_i   (wa0),
            .wd0_i   (wd0),
            .we1_i   (we1_act),
            .wa1_i   (wa1),
            .wd1_i   (wd1),
            .rd_o    (rd[i*DATA_W +: DATA_W])
        );
    end

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with default parameters (32x32, two read ports).
module tb_register_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr_req;
    logic                   busy;
    logic                   we0, we1;
    logic [ADDR_W-1:0]      wa0, wa1;
    logic [DATA_W-1:0]      wd0, wd1;
    logic [N_RD*ADDR_W-1:0] ra;
    logic [N_RD*DATA_W-1:0] rd;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    register_file_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .N_RD     (N_RD),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .we0     (we0),
        .we1     (we1),
        .wa0     (wa0),
        .wa1     (wa1),
        .wd0     (wd0),
        .wd1     (wd1),
        .ra      (ra),
        .rd      (rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            ra[4:0] = a[4:0];
            #1;
            check($sformatf("%s_row%0d", tag, a), rd[31:0], 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;

        // Reset sweep with a write attempt held throughout.
        tick();
        rst = 1'b0;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hFFFF_FFFF;
        ra[4:0] = 5'd3; ra[9:5] = 5'd0;
        @(negedge clk);
        check("busy_after_rst", {31'b0, busy}, 32'd1);
        check("rd0_busy", rd[31:0], 32'h0);
        check("rd1_busy", rd[63:32], 32'h0);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        we0 = 1'b0;
        check("rst_busy_cycles", cnt, 32'd32);
        #1;
        check("dropped_write_row3", rd[31:0], 32'h0);
        check_all_zero("rst_clear");

        // Dual write collision: port 1 wins, also visible through bypass.
        tick();
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
        wd0 = 32'h1111_1111; wd1 = 32'h2222_2222;
        ra[9:5] = 5'd7;
        #1;
        check("collide_bypass", rd[63:32], 32'h2222_2222);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        ra[4:0] = 5'd7;
        #1;
        check("collide_stored", rd[31:0], 32'h2222_2222);

        // Zero register.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF; ra[4:0] = 5'd0;
        #1;
        check("zero_same_cycle", rd[31:0], 32'h0);
        tick();
        we0 = 1'b0;
        #1;
        check("zero_next_cycle", rd[31:0], 32'h0);

        // Bypass on port 1 with port 0 reading the same address.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hA5A5_A5A5;
        ra[9:5] = 5'd5; ra[4:0] = 5'd5;
        #1;
        check("bypass_p1", rd[63:32], 32'hA5A5_A5A5);
        check("bypass_p0", rd[31:0], 32'hA5A5_A5A5);
        tick();
        we0 = 1'b0;
        #1;
        check("bypass_stored", rd[63:32], 32'hA5A5_A5A5);

        // Fill rows 1..31 with their index through alternating ports.
        for (int i = 1; i < 32; i++) begin
            if (i % 2 == 0) begin
                we0 = 1'b1; wa0 = i[4:0]; wd0 = i;
                we1 = 1'b0;
            end else begin
                we1 = 1'b1; wa1 = i[4:0]; wd1 = i;
                we0 = 1'b0;
            end
            tick();
        end
        we0 = 1'b0; we1 = 1'b0;
        ra[4:0] = 5'd17; ra[9:5] = 5'd17;
        #1;
        check("fill_row17_p0", rd[31:0], 32'd17);
        check("fill_row17_p1", rd[63:32], 32'd17);
        ra[4:0] = 5'd30; ra[9:5] = 5'd31;
        #1;
        check("fill_row30", rd[31:0], 32'd30);
        check("fill_row31", rd[63:32], 32'd31);

        // clr_req together with a write, then a second clr_req and a mid-sweep rst.
        clr_req = 1'b1;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9999_9999;
        tick();
        clr_req = 1'b0; we1 = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            clr_req = (cnt == 5);
            rst     = (cnt == 11);
        end
        clr_req = 1'b0; rst = 1'b0;
        check("restart_busy_cycles", cnt, 32'd43);
        check_all_zero("restart_clear");
        ra[9:5] = 5'd9;
        #1;
        check("same_cycle_write_cleared", rd[63:32], 32'h0);

        tick();
        check("busy_idle_end", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_register_file_mp

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file; the next generation of the processor's 32x32 register file. It provides N_RD combinational read ports, two write ports with fixed priority, optional same-cycle write-to-read bypass and an optional hardwired zero register. Instead of a single-cycle bulk reset, a sequential clear engine sweeps one row per cycle after reset or on request, which keeps the storage mappable to distributed RAM. It sits in the decode stage, between the writeback bus and the operand muxes.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W rows
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, row 0 always reads 0 and ignores writes
- BYPASS, 1, when 1, a read of an address being written this cycle returns the write data
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- clr_req  in  1  single-cycle pulse; starts a clear sweep when the FSM is idle
- busy  out  1  high while a clear sweep is in progress
- we0, we1  in  1 each  write enables; port 1 has priority
- wa0, wa1  in  ADDR_W each  write addresses
- wd0, wd1  in  DATA_W each  write data
- ra  in  N_RD*ADDR_W  packed read addresses; port i is at [i*ADDR_W +: ADDR_W]
- rd  out  N_RD*DATA_W  packed read data; port i is at [i*DATA_W +: DATA_W]

## Operation
- FSM states:
  - IDLE: normal read/write.
  - CLEAR: each cycle writes 0 to row ptr, then ptr increments.
- Transitions:
  - rst forces CLEAR with ptr=0, from any state.
  - IDLE to CLEAR when clr_req=1; ptr=0.
  - CLEAR to IDLE after the cycle with ptr = DEPTH-1. ptr then wraps to 0.
- busy = (state == CLEAR). It is a registered output.
- While busy:
  - we0 and we1 are dropped and have no effect.
  - All rd ports return 0.
  - clr_req is ignored; the sweep does not restart.
- Writes in IDLE:
  - Committed at the rising edge.
  - If we0 and we1 are both set and wa0 == wa1, wd1 is stored.
  - If ZERO_REG=1, writes to row 0 are discarded.
- Reads in IDLE are combinational from ra.
  - If ZERO_REG=1 and the address is 0, rd = 0.
  - If BYPASS=1, the read address matches an enabled write address and the address is nonzero (or ZERO_REG=0), rd returns that write's data. wd1 takes precedence over wd0.
  - Otherwise rd returns the stored row.
- Read ports are independent. Any number of ports may read the same address.

## Timing
- Reset values: busy=1 and state=CLEAR from the cycle after rst is sampled. All rd ports are 0 while busy.
- Clear latency: DEPTH cycles after rst deasserts, or after the clr_req edge, busy falls. Example: 32 cycles for ADDR_W=5. busy=0 and writes are accepted on cycle DEPTH.
- rst asserted mid-sweep restarts the sweep at ptr=0, with the full DEPTH latency again.
- clr_req in the same cycle as writes in IDLE: those writes commit, then the sweep starts next cycle and zeroes them.
- Write-to-read latency:
  - BYPASS=1: 0 cycles, visible in the same cycle.
  - BYPASS=0: 1 cycle; the read sees the old value in the write cycle.
- No read latency; rd settles combinationally within the cycle.

## Structure
- Package regfile_pkg holds:
  - the state enum: RF_IDLE, RF_CLEAR
  - default width constants: RF_DATA_W=32, RF_ADDR_W=5
- Sub-module rf_read_port contains:
  - the per-port row-select mux
  - the zero-register override
  - the bypass compare (parametrised by BYPASS and ZERO_REG)
- rf_read_port is instantiated N_RD times in a generate loop. Storage, write priority and the clear FSM stay in the top module.

## Test plan
- Reset sweep: pulse rst for 1 cycle.
  - busy=1 for exactly 32 cycles, then busy=0.
  - Every row reads 0.
  - we0 with wa0=3 during the sweep is dropped; row 3 = 0 after busy falls.
- Dual write collision: we0=we1=1, wa0=wa1=7, wd0=0x1111_1111, wd1=0x2222_2222.
  - Next cycle, ra port 0 = 7 gives rd = 0x2222_2222.
- Zero register: we0=1, wa0=0, wd0=0xDEAD_BEEF.
  - Read of 0 returns 0, both in the same cycle and on the next cycle.
- Bypass: write wa0=5, wd0=0xA5A5_A5A5, with ra port 1 = 5 in the same cycle.
  - BYPASS=1: rd port 1 = 0xA5A5_A5A5 in that cycle.
  - BYPASS=0: 0 in that cycle, 0xA5A5_A5A5 on the next cycle.
- Mid-sweep restart and clr_req:
  - Fill rows 1..31 with their index, pulse clr_req, then assert rst at sweep cycle 10.
  - busy stays high for 10 + 1 + 32 cycles total.
  - All rows read 0 afterwards.
  - A second clr_req issued during the sweep does not extend busy.
